// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, FSM encoding and request payload for the core memory-port arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned MemBusWidth        = 32;
    localparam int unsigned AddrWidth          = 32;
    localparam int unsigned BeWidth            = 4;
    localparam int unsigned StarveCntWidth     = 4;
    localparam int unsigned StarveLimitDefault = 4;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_LSU = 2'd2
    } arb_state_e;

    // Transaction captured at grant time and held on the bus until mem_ready.
    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic [MemBusWidth-1:0] wdata;
        logic [BeWidth-1:0]     be;
        logic                   we;
    } mem_req_t;

    function automatic logic [MemBusWidth-1:0] data_gate(input logic en,
                                                         input logic [MemBusWidth-1:0] d);
        return en ? d : '0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, response and memory-pin signals of the arbiter, bundled with arbiter/environment views.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    // fetch requester
    logic                   if_req;
    logic [AddrWidth-1:0]   if_addr;
    logic                   if_kill;
    logic                   if_gnt;
    logic                   if_rsp_valid;
    logic [MemBusWidth-1:0] if_rdata;

    // data requester
    logic                   lsu_req;
    logic [AddrWidth-1:0]   lsu_addr;
    logic                   lsu_we;
    logic [BeWidth-1:0]     lsu_be;
    logic [MemBusWidth-1:0] lsu_wdata;
    logic                   lsu_gnt;
    logic                   lsu_rsp_valid;
    logic [MemBusWidth-1:0] lsu_rdata;

    // memory pins
    logic [AddrWidth-1:0]   mem_addr;
    logic [MemBusWidth-1:0] mem_data_out;
    logic [MemBusWidth-1:0] mem_data_in;
    logic [BeWidth-1:0]     mem_wr_en;
    logic                   mem_rd_en;
    logic                   mem_valid;
    logic                   mem_ready;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  lsu_req, lsu_addr, lsu_we, lsu_be, lsu_wdata,
        input  mem_data_in, mem_ready,
        output if_gnt, if_rsp_valid, if_rdata,
        output lsu_gnt, lsu_rsp_valid, lsu_rdata,
        output mem_addr, mem_data_out, mem_wr_en, mem_rd_en, mem_valid
    );

    modport master (
        output if_req, if_addr, if_kill,
        output lsu_req, lsu_addr, lsu_we, lsu_be, lsu_wdata,
        output mem_data_in, mem_ready,
        input  if_gnt, if_rsp_valid, if_rdata,
        input  lsu_gnt, lsu_rsp_valid, lsu_rdata,
        input  mem_addr, mem_data_out, mem_wr_en, mem_rd_en, mem_valid
    );

endinterface

// File: rtl/mem_bus_arbiter_arb_prio_sel.sv
// Fixed LSU-over-fetch priority with a starvation counter that forces a fetch grant
// after StarveLimit consecutive LSU grants taken while fetch was waiting.
module arb_prio_sel
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = StarveLimitDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic lsu_req_i,
    input  logic if_gnt_i,
    input  logic lsu_gnt_i,
    output logic sel_if_c_o,
    output logic sel_lsu_c_o
);

    localparam logic [StarveCntWidth-1:0] StarveMax = StarveCntWidth'(StarveLimit);

    logic [StarveCntWidth-1:0] starve_cnt_q;
    logic [StarveCntWidth-1:0] starve_cnt_d;
    logic                      if_forced_c;

    assign if_forced_c = if_req_i && (starve_cnt_q == StarveMax);
    assign sel_lsu_c_o = lsu_req_i && !if_forced_c;
    assign sel_if_c_o  = if_req_i && !sel_lsu_c_o;

    // Any fetch grant clears; LSU grants that bypass a waiting fetch count up and saturate.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt_i) begin
            starve_cnt_d = '0;
        end else if (lsu_gnt_i && if_req_i && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + StarveCntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single core memory port between instruction fetch and the LSU,
// one outstanding transaction at a time, with registered one-cycle responses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = StarveLimitDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.slave  bus_io
);

    arb_state_e             state_q;
    arb_state_e             state_d;
    mem_req_t               req_q;
    mem_req_t               req_d;
    logic                   drop_q;
    logic                   drop_d;
    logic                   if_rsp_q;
    logic                   if_rsp_d;
    logic                   lsu_rsp_q;
    logic                   lsu_rsp_d;
    logic [MemBusWidth-1:0] if_rdata_q;
    logic [MemBusWidth-1:0] if_rdata_d;
    logic [MemBusWidth-1:0] lsu_rdata_q;
    logic [MemBusWidth-1:0] lsu_rdata_d;

    logic                   if_gnt_c;
    logic                   lsu_gnt_c;
    logic                   sel_if_c;
    logic                   sel_lsu_c;
    logic                   store_c;

    arb_prio_sel #(
        .StarveLimit (StarveLimit)
    ) u_prio_sel (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (bus_io.if_req),
        .lsu_req_i   (bus_io.lsu_req),
        .if_gnt_i    (if_gnt_c),
        .lsu_gnt_i   (lsu_gnt_c),
        .sel_if_c_o  (sel_if_c),
        .sel_lsu_c_o (sel_lsu_c)
    );

    // Next state, grants, response pulses and capture of the granted request.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        drop_d      = drop_q;
        if_rsp_d    = 1'b0;
        lsu_rsp_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        if_gnt_c    = 1'b0;
        lsu_gnt_c   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                // Grants are held off while reset is asserted so every output reads 0.
                if (rst_n && sel_lsu_c) begin
                    lsu_gnt_c = 1'b1;
                    req_d     = '{addr:  bus_io.lsu_addr,
                                  wdata: bus_io.lsu_wdata,
                                  be:    bus_io.lsu_be,
                                  we:    bus_io.lsu_we};
                    state_d   = ARB_BUSY_LSU;
                end else if (rst_n && sel_if_c) begin
                    if_gnt_c = 1'b1;
                    req_d    = '{addr:  bus_io.if_addr,
                                 wdata: '0,
                                 be:    '0,
                                 we:    1'b0};
                    state_d  = ARB_BUSY_IF;
                end
            end

            ARB_BUSY_IF: begin
                if (bus_io.if_kill) begin
                    drop_d = 1'b1;
                end
                if (bus_io.mem_ready) begin
                    state_d = ARB_IDLE;
                    // A kill on the completion cycle itself still drops the response.
                    if (!(drop_q || bus_io.if_kill)) begin
                        if_rsp_d   = 1'b1;
                        if_rdata_d = bus_io.mem_data_in;
                    end
                end
            end

            ARB_BUSY_LSU: begin
                if (bus_io.mem_ready) begin
                    state_d     = ARB_IDLE;
                    lsu_rsp_d   = 1'b1;
                    lsu_rdata_d = data_gate(!req_q.we, bus_io.mem_data_in);
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            drop_q      <= 1'b0;
            if_rsp_q    <= 1'b0;
            lsu_rsp_q   <= 1'b0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
        end else begin
            req_q       <= req_d;
            drop_q      <= drop_d;
            if_rsp_q    <= if_rsp_d;
            lsu_rsp_q   <= lsu_rsp_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign store_c = (state_q == ARB_BUSY_LSU) && req_q.we;

    assign bus_io.if_gnt        = if_gnt_c;
    assign bus_io.lsu_gnt       = lsu_gnt_c;
    assign bus_io.if_rsp_valid  = if_rsp_q;
    assign bus_io.if_rdata      = if_rdata_q;
    assign bus_io.lsu_rsp_valid = lsu_rsp_q;
    assign bus_io.lsu_rdata     = lsu_rdata_q;

    assign bus_io.mem_valid     = (state_q != ARB_IDLE);
    assign bus_io.mem_rd_en     = (state_q == ARB_BUSY_IF);
    assign bus_io.mem_addr      = req_q.addr;
    assign bus_io.mem_wr_en     = store_c ? req_q.be : '0;
    assign bus_io.mem_data_out  = data_gate(store_c, req_q.wdata);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model predicts grants,
// bus contents and responses; a separate monitor pops expected responses as they appear.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int unsigned Limit = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.StarveLimit(Limit)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory-side drive: either manual values from the directed code or random ones
    bit          mem_manual = 1'b1;
    bit          rdy_always = 1'b1;
    bit          kill_rand  = 1'b0;
    logic        man_ready  = 1'b0;
    logic [31:0] man_data   = '0;
    logic        man_kill   = 1'b0;
    logic        rnd_ready  = 1'b0;
    logic [31:0] rnd_data   = '0;
    logic        rnd_kill   = 1'b0;

    assign bus.mem_ready   = mem_manual ? man_ready : rnd_ready;
    assign bus.mem_data_in = mem_manual ? man_data  : rnd_data;
    assign bus.if_kill     = mem_manual ? man_kill  : rnd_kill;

    initial forever begin
        @(posedge clk); #1;
        rnd_ready = rdy_always ? 1'b1 : ($urandom_range(0, 2) == 0);
        rnd_data  = $urandom;
        rnd_kill  = kill_rand && ($urandom_range(0, 5) == 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] dout;
        logic [3:0]  wr;
        logic        rd;
        logic        is_lsu;
        logic        we;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } rsp_exp_t;

    bus_exp_t    m_cur;
    bit          m_busy   = 1'b0;
    bit          m_drop   = 1'b0;
    int unsigned m_starve = 0;
    rsp_exp_t    if_q[$];
    rsp_exp_t    lsu_q[$];
    byte         gnt_log[$];
    int unsigned rsp_cycles[$];
    int unsigned if_rsp_cnt  = 0;
    int unsigned lsu_rsp_cnt = 0;

    always @(negedge clk) begin
        bit exp_l, exp_i;
        if (!rst_n) begin
            m_busy = 0; m_drop = 0; m_starve = 0;
            if_q.delete(); lsu_q.delete();
            chk("rst_ctrl", 64'({bus.if_gnt, bus.lsu_gnt, bus.if_rsp_valid, bus.lsu_rsp_valid,
                                 bus.mem_valid, bus.mem_rd_en, bus.mem_wr_en}), 64'd0);
            chk("rst_addr", 64'(bus.mem_addr), 64'd0);
            chk("rst_dout", 64'(bus.mem_data_out), 64'd0);
            chk("rst_rdata", {bus.if_rdata, bus.lsu_rdata}, 64'd0);
        end else if (!m_busy) begin
            exp_l = bus.lsu_req && !(bus.if_req && m_starve == Limit);
            exp_i = bus.if_req && !exp_l;
            chk("grant", 64'({bus.if_gnt, bus.lsu_gnt}), 64'({exp_i, exp_l}));
            chk("idle_mem_valid", 64'(bus.mem_valid), 64'd0);
            if (exp_l) begin
                m_cur = '{addr: bus.lsu_addr, dout: bus.lsu_we ? bus.lsu_wdata : 32'd0,
                          wr: bus.lsu_we ? bus.lsu_be : 4'd0, rd: 1'b0, is_lsu: 1'b1,
                          we: bus.lsu_we};
                if (bus.if_req && m_starve < Limit) m_starve++;
                gnt_log.push_back("L");
                m_busy = 1;
            end else if (exp_i) begin
                m_cur = '{addr: bus.if_addr, dout: 32'd0, wr: 4'd0, rd: 1'b1, is_lsu: 1'b0,
                          we: 1'b0};
                m_starve = 0;
                gnt_log.push_back("I");
                m_busy = 1;
            end
        end else begin
            chk("busy_grant", 64'({bus.if_gnt, bus.lsu_gnt}), 64'd0);
            chk("mem_valid", 64'(bus.mem_valid), 64'd1);
            chk("mem_addr", 64'(bus.mem_addr), 64'(m_cur.addr));
            chk("mem_data_out", 64'(bus.mem_data_out), 64'(m_cur.dout));
            chk("mem_wr_en", 64'(bus.mem_wr_en), 64'(m_cur.wr));
            chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(m_cur.rd));
            if (!m_cur.is_lsu && bus.if_kill) m_drop = 1;
            if (bus.mem_ready) begin
                if (m_cur.is_lsu)
                    lsu_q.push_back('{data: m_cur.we ? 32'd0 : bus.mem_data_in, cyc: cyc + 1});
                else if (!m_drop)
                    if_q.push_back('{data: bus.mem_data_in, cyc: cyc + 1});
                m_busy = 0;
                m_drop = 0;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        rsp_exp_t e;
        if (rst_n) begin
            if (bus.if_rsp_valid) begin
                if_rsp_cnt++;
                rsp_cycles.push_back(cyc);
                if (if_q.size() == 0) begin
                    chk("if_rsp_unexpected", 64'(bus.if_rsp_valid), 64'd0);
                end else begin
                    e = if_q.pop_front();
                    chk("if_rdata", 64'(bus.if_rdata), 64'(e.data));
                    chk("if_rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (if_q.size() > 0 && if_q[0].cyc <= cyc) begin
                e = if_q.pop_front();
                chk("if_rsp_missing", 64'(bus.if_rsp_valid), 64'd1);
            end
            if (bus.lsu_rsp_valid) begin
                lsu_rsp_cnt++;
                rsp_cycles.push_back(cyc);
                if (lsu_q.size() == 0) begin
                    chk("lsu_rsp_unexpected", 64'(bus.lsu_rsp_valid), 64'd0);
                end else begin
                    e = lsu_q.pop_front();
                    chk("lsu_rdata", 64'(bus.lsu_rdata), 64'(e.data));
                    chk("lsu_rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (lsu_q.size() > 0 && lsu_q[0].cyc <= cyc) begin
                e = lsu_q.pop_front();
                chk("lsu_rsp_missing", 64'(bus.lsu_rsp_valid), 64'd1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt(input bit lsu);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = lsu ? bus.lsu_gnt : bus.if_gnt;
        end
        if (!seen) chk(lsu ? "lsu_gnt_timeout" : "if_gnt_timeout", 64'(seen), 64'd1);
    endtask

    task automatic if_driver(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
            bus.if_req  = 1'b1;
            wait_gnt(1'b0);
            tick();
            bus.if_req = 1'b0;
        end
    endtask

    task automatic lsu_driver(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.lsu_addr  = $urandom & 32'hFFFF_FFFC;
            bus.lsu_we    = 1'($urandom_range(0, 1));
            bus.lsu_be    = 4'($urandom);
            bus.lsu_wdata = $urandom;
            bus.lsu_req   = 1'b1;
            wait_gnt(1'b1);
            tick();
            bus.lsu_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int unsigned cnt, base;
        byte exp_order[10];
        exp_order = '{"L", "L", "L", "L", "I", "L", "L", "L", "L", "I"};

        bus.if_req = 0; bus.if_addr = '0;
        bus.lsu_req = 0; bus.lsu_addr = '0; bus.lsu_we = 0; bus.lsu_be = '0; bus.lsu_wdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // lone fetch: grant at N, bus at N+1, response at N+2
        man_ready = 1'b1; man_data = 32'h0000_0013;
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        wait_gnt(1'b0);
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("fetch_bus_addr", 64'(bus.mem_addr), 64'h100);
        chk("fetch_rd_en", 64'({bus.mem_valid, bus.mem_rd_en}), 64'd3);
        @(negedge clk);
        chk("fetch_rsp", 64'(bus.if_rsp_valid), 64'd1);
        chk("fetch_rdata", 64'(bus.if_rdata), 64'h13);
        tick();

        // store with three wait states
        man_ready = 1'b0;
        bus.lsu_addr = 32'h2004; bus.lsu_we = 1'b1; bus.lsu_be = 4'b0011;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_req = 1'b1;
        wait_gnt(1'b1);
        tick();
        bus.lsu_req = 1'b0; bus.lsu_we = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            man_ready = (k == 3);
            @(negedge clk);
            if (bus.mem_valid && bus.mem_wr_en == 4'b0011 && bus.mem_data_out == 32'hDEAD_BEEF)
                cnt++;
            tick();
        end
        man_ready = 1'b0;
        chk("store_stable_cycles", 64'(cnt), 64'd4);
        @(negedge clk);
        chk("store_rsp", 64'(bus.lsu_rsp_valid), 64'd1);
        chk("store_rdata", 64'(bus.lsu_rdata), 64'd0);
        tick();

        // reset while a load is stalled on the bus
        bus.lsu_addr = 32'h40; bus.lsu_req = 1'b1;
        wait_gnt(1'b1);
        tick();
        bus.lsu_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midop_rst_valid", 64'({bus.mem_valid, bus.mem_rd_en, bus.mem_wr_en}), 64'd0);
        chk("midop_rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("midop_rst_rsp", 64'({bus.if_rsp_valid, bus.lsu_rsp_valid}), 64'd0);
        tick(); tick();
        rst_n = 1'b1; man_ready = 1'b1;
        base = lsu_rsp_cnt;
        repeat (4) tick();
        chk("midop_no_rsp", 64'(lsu_rsp_cnt - base), 64'd0);

        // contention with both requests held high
        gnt_log.delete();
        bus.if_addr = 32'h400; bus.lsu_addr = 32'h800; bus.lsu_we = 1'b0;
        bus.if_req = 1'b1; bus.lsu_req = 1'b1;
        for (int k = 0; k < 60 && gnt_log.size() < 10; k++) @(posedge clk);
        #1;
        bus.if_req = 1'b0; bus.lsu_req = 1'b0;
        chk("starve_grants", 64'(gnt_log.size() >= 10), 64'd1);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++)
            chk("starve_order", 64'(gnt_log[i]), 64'(exp_order[i]));
        repeat (3) tick();

        // kill on the first bus cycle, completion two cycles later
        man_ready = 1'b0;
        bus.if_addr = 32'h300; bus.if_req = 1'b1;
        base = if_rsp_cnt;
        wait_gnt(1'b0);
        tick();
        bus.if_req = 1'b0; man_kill = 1'b1;
        tick();
        man_kill = 1'b0;
        tick();
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        tick();
        chk("kill_suppressed", 64'(if_rsp_cnt - base), 64'd0);
        man_ready = 1'b1; man_data = 32'h0000_0093;
        bus.if_addr = 32'h304; bus.if_req = 1'b1;
        wait_gnt(1'b0);
        tick();
        bus.if_req = 1'b0;
        tick(); tick();
        chk("post_kill_rsp", 64'(if_rsp_cnt - base), 64'd1);

        // back-to-back alternating loads and fetches
        mem_manual = 1'b0; rdy_always = 1'b1; kill_rand = 1'b0;
        tick();
        rsp_cycles.delete();
        bus.lsu_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                bus.lsu_addr = $urandom & 32'hFFFF_FFFC; bus.lsu_req = 1'b1;
                wait_gnt(1'b1);
                tick();
                bus.lsu_req = 1'b0;
            end else begin
                bus.if_addr = $urandom & 32'hFFFF_FFFC; bus.if_req = 1'b1;
                wait_gnt(1'b0);
                tick();
                bus.if_req = 1'b0;
            end
        end
        repeat (3) tick();
        chk("b2b_count", 64'(rsp_cycles.size()), 64'd6);
        for (int i = 1; i < 6 && i < rsp_cycles.size(); i++)
            chk("b2b_spacing", 64'(rsp_cycles[i] - rsp_cycles[i-1]), 64'd2);

        // randomized traffic with wait states and kills
        rdy_always = 1'b0; kill_rand = 1'b1;
        fork
            if_driver(80);
            lsu_driver(80);
        join
        kill_rand = 1'b0; rdy_always = 1'b1;
        repeat (10) tick();
        chk("if_q_drained", 64'(if_q.size()), 64'd0);
        chk("lsu_q_drained", 64'(lsu_q.size()), 64'd0);
        chk("bus_idle_end", 64'(bus.mem_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the core's single memory port (mem_addr/mem_data_in/mem_data_out/mem_wr_en/mem_rd_en/mem_valid/mem_ready) between the IF-stage fetch requester and the LSU data requester. It sits in riscv_core between if_stage/mem_stage and the top-level memory pins. It runs one outstanding transaction at a time. LSU has fixed priority, and a starvation counter guarantees fetch progress.

Parameters:
MemBusWidth, 32, data width of memory and requester data buses (from param_defs)
AddrWidth, 32, address width
StarveLimit, 4, consecutive LSU grants with IF waiting before IF is forced to win; legal range 1..15

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  AddrWidth  fetch address
if_kill  in  1  discard the in-flight fetch response (redirect)
if_gnt  out  1  fetch request accepted this cycle
if_rsp_valid  out  1  one-cycle pulse, fetch data valid
if_rdata  out  MemBusWidth  fetch data
lsu_req  in  1  data request, held until lsu_gnt
lsu_addr  in  AddrWidth  data address
lsu_we  in  1  1 = store
lsu_be  in  4  store byte enables
lsu_wdata  in  MemBusWidth  store data
lsu_gnt  out  1  data request accepted this cycle
lsu_rsp_valid  out  1  one-cycle pulse, load data valid or store done
lsu_rdata  out  MemBusWidth  load data (0 for stores)
mem_addr  out  AddrWidth  bus address
mem_data_out  out  MemBusWidth  bus write data
mem_wr_en  out  4  byte write strobes
mem_rd_en  out  1  1 = transaction is an instruction fetch
mem_valid  out  1  bus request valid
mem_ready  in  1  bus completes the transaction this cycle

Behaviour:
- Reset (async, rst_n low): state=IDLE, starve_cnt=0. All outputs are 0, including mem_addr, mem_data_out, rdata buses and all pulses. A transaction in flight is abandoned and no response is generated.
- States: IDLE, BUSY_IF, BUSY_LSU.
- IDLE:
  - if_gnt/lsu_gnt are combinational and only asserted in IDLE; at most one is high.
  - Selection: lsu_req && !(if_req && starve_cnt==StarveLimit) grants LSU; otherwise if_req grants IF.
  - On grant, register addr, wdata, be and we. Move to the BUSY state of the granted requester.
- BUSY_x:
  - mem_valid=1 with registered fields. mem_rd_en=1 only in BUSY_IF.
  - mem_wr_en=lsu_be only for a store; it is 0 for loads and fetches. mem_data_out=0 unless the transaction is a store.
  - Fields are stable until mem_ready.
- Completion: when mem_valid && mem_ready, the next edge returns to IDLE. x_rsp_valid pulses for exactly one cycle after that edge. x_rdata captures mem_data_in (0 for stores) and holds until the next response to the same requester.
- Latency and throughput: grant at cycle N, mem_valid at N+1. If mem_ready arrives at N+1, the response appears at N+2 and a new grant is possible at N+2. Peak rate is one transaction per 2 cycles. mem_ready in IDLE is ignored.
- if_kill:
  - Sampled in BUSY_IF or in the completion cycle. Any kill seen sets a sticky drop flag.
  - The bus transaction still completes, but if_rsp_valid is suppressed.
  - Drop flag clears in IDLE.
  - if_kill in IDLE has no effect.
- starve_cnt:
  - Increments (saturating at StarveLimit) on each LSU grant while if_req=1.
  - Clears on any IF grant.
  - Holds otherwise.
- Simultaneous requests: LSU wins unless starve_cnt==StarveLimit.
- Requester dropping req before grant is legal; it is simply not granted.

Decomposition:
- param_defs: MemBusWidth, AddrWidth.
- instr_defs or a new arb package: arb_state_e enum {IDLE, BUSY_IF, BUSY_LSU}.
- The starvation counter/priority select forms a small natural sub-module, arb_prio_sel (inputs: if_req, lsu_req, grant strobes; outputs: sel_if, sel_lsu). The FSM and datapath registers stay in mem_bus_arbiter.

Test Plan:
- Reset mid-op: assert rst_n=0 in BUSY_LSU with mem_ready=0 -> all outputs 0 immediately; after release, no lsu_rsp_valid.
- Lone fetch: if_req=1, if_addr=0x100, mem_ready=1 always, mem_data_in=0x00000013 -> if_gnt at N, mem_valid/mem_rd_en/mem_addr=0x100 at N+1, if_rsp_valid with if_rdata=0x13 at N+2.
- Store with wait states: lsu_we=1, lsu_be=4'b0011, lsu_wdata=0xDEADBEEF, lsu_addr=0x2004, mem_ready low for 3 cycles -> mem_wr_en=0011, mem_data_out=0xDEADBEEF stable for 4 cycles, then lsu_rsp_valid pulse with lsu_rdata=0.
- Contention/starvation: if_req and lsu_req held high, StarveLimit=4 -> grant order L,L,L,L,I,L,L,L,L,I...
- Kill: IF granted, if_kill pulsed at mem_valid cycle, mem_ready 2 cycles later -> bus completes, no if_rsp_valid, next IF response delivered normally.
- Back-to-back: alternating loads and fetches with mem_ready=1 -> one response every 2 cycles, no gap or double grant.
